// File: rtl/heartbeat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : heartbeat_pkg
// Description : Shared level encodings, FSM state type, default timing
//               constants and a clamp helper for the heartbeat pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
package heartbeat_pkg;

    localparam logic [1:0] HB_CALM    = 2'd0;
    localparam logic [1:0] HB_NORMAL  = 2'd1;
    localparam logic [1:0] HB_EXCITED = 2'd2;
    localparam logic [1:0] HB_RACING  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SYSTOLE  = 2'd1,
        ST_DIASTOLE = 2'd2
    } hb_state_t;

    localparam int c_DEF_LEVEL_W     = 2;
    localparam int c_DEF_PERIOD_W    = 16;
    localparam int c_DEF_BASE_PERIOD = 1000;
    localparam int c_DEF_STEP        = 150;
    localparam int c_DEF_SLEEP_EXTRA = 400;
    localparam int c_DEF_MIN_PERIOD  = 100;
    localparam int c_DEF_SLEW_STEP   = 25;
    localparam int c_DEF_PULSE_LEN   = 40;

    function automatic int clamp_period(input int p, input int lo, input int hi);
        if (p < lo)
            return lo;
        else if (p > hi)
            return hi;
        else
            return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/heartbeat_pulse_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : heartbeat_pulse_gen_if
// Description : Control inputs and beat outputs of the heartbeat pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface heartbeat_pulse_gen_if
    import heartbeat_pkg::*;
#(
    parameter int LEVEL_W  = c_DEF_LEVEL_W,
    parameter int PERIOD_W = c_DEF_PERIOD_W
);
    logic                en;
    logic                tick;
    logic [LEVEL_W-1:0]  heartbeat_level;
    logic                sleeping;
    logic                beat;
    logic                beat_led;
    logic [PERIOD_W-1:0] period;
    logic [7:0]          beat_count;

    modport master (
        output en, tick, heartbeat_level, sleeping,
        input  beat, beat_led, period, beat_count
    );

    modport slave (
        input  en, tick, heartbeat_level, sleeping,
        output beat, beat_led, period, beat_count
    );
endinterface
`default_nettype wire

// File: rtl/heartbeat_period_slew.sv
`default_nettype none
// ============================================================================
// Module      : heartbeat_period_slew
// Description : Combinational target-period computation with clamping, and a
//               rate-limited step of the current period toward that target.
// Revision    : 1.0 - initial release
// ============================================================================
module heartbeat_period_slew
    import heartbeat_pkg::*;
#(
    parameter int LEVEL_W     = c_DEF_LEVEL_W,
    parameter int PERIOD_W    = c_DEF_PERIOD_W,
    parameter int BASE_PERIOD = c_DEF_BASE_PERIOD,
    parameter int STEP        = c_DEF_STEP,
    parameter int SLEEP_EXTRA = c_DEF_SLEEP_EXTRA,
    parameter int MIN_PERIOD  = c_DEF_MIN_PERIOD,
    parameter int SLEW_STEP   = c_DEF_SLEW_STEP
) (
    input  wire logic [LEVEL_W-1:0]  i_level,
    input  wire logic                i_sleeping,
    input  wire logic [PERIOD_W-1:0] i_period,
    output logic      [PERIOD_W-1:0] o_next_period
);
    // Two guard bits beyond the level product keep the sum sign-correct before clamping.
    localparam int c_TW = PERIOD_W + LEVEL_W + 2;
    localparam logic signed [c_TW-1:0] c_MIN  = c_TW'(MIN_PERIOD);
    localparam logic signed [c_TW-1:0] c_MAX  = c_TW'((2 ** PERIOD_W) - 1);
    localparam logic [PERIOD_W-1:0]    c_SLEW = PERIOD_W'(SLEW_STEP);

    logic signed [c_TW-1:0] w_raw;
    logic [PERIOD_W-1:0]    w_target;
    logic [PERIOD_W-1:0]    w_up;
    logic [PERIOD_W-1:0]    w_dn;

    always_comb begin
        w_raw = $signed(c_TW'(BASE_PERIOD))
              - $signed(c_TW'(i_level)) * $signed(c_TW'(STEP))
              + (i_sleeping ? $signed(c_TW'(SLEEP_EXTRA)) : $signed(c_TW'(0)));

        if (w_raw < c_MIN)
            w_target = PERIOD_W'(MIN_PERIOD);
        else if (w_raw > c_MAX)
            w_target = '1;
        else
            w_target = w_raw[PERIOD_W-1:0];

        w_up          = w_target - i_period;
        w_dn          = i_period - w_target;
        o_next_period = i_period;
        if (w_target > i_period)
            o_next_period = i_period + ((w_up > c_SLEW) ? c_SLEW : w_up);
        else if (w_target < i_period)
            o_next_period = i_period - ((w_dn > c_SLEW) ? c_SLEW : w_dn);
    end
endmodule
`default_nettype wire

// File: rtl/heartbeat_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : heartbeat_pulse_gen
// Description : Tick-timed beat pulse train whose period slews toward a
//               level/sleep dependent target; holds FSM, tick and beat counters.
// Revision    : 1.0 - initial release
// ============================================================================
module heartbeat_pulse_gen
    import heartbeat_pkg::*;
#(
    parameter int LEVEL_W     = c_DEF_LEVEL_W,
    parameter int PERIOD_W    = c_DEF_PERIOD_W,
    parameter int BASE_PERIOD = c_DEF_BASE_PERIOD,
    parameter int STEP        = c_DEF_STEP,
    parameter int SLEEP_EXTRA = c_DEF_SLEEP_EXTRA,
    parameter int MIN_PERIOD  = c_DEF_MIN_PERIOD,
    parameter int SLEW_STEP   = c_DEF_SLEW_STEP,
    parameter int PULSE_LEN   = c_DEF_PULSE_LEN
) (
    input wire logic             clk,
    input wire logic             rst,
    heartbeat_pulse_gen_if.slave hb
);
    localparam logic [PERIOD_W-1:0] c_RESET_PERIOD =
        PERIOD_W'(clamp_period(BASE_PERIOD, MIN_PERIOD, (2 ** PERIOD_W) - 1));
    localparam logic [PERIOD_W-1:0] c_PULSE_LAST = PERIOD_W'(PULSE_LEN - 1);
    localparam logic [PERIOD_W-1:0] c_ONE        = PERIOD_W'(1);

    hb_state_t           r_state, w_state_nxt;
    logic [PERIOD_W-1:0] r_cnt, w_cnt_nxt;
    logic [PERIOD_W-1:0] r_period, w_period_nxt;
    logic [PERIOD_W-1:0] w_slewed;
    logic [7:0]          r_count, w_count_nxt;
    logic                r_beat, w_beat_nxt;
    logic                r_led;

    heartbeat_period_slew #(
        .LEVEL_W     (LEVEL_W),
        .PERIOD_W    (PERIOD_W),
        .BASE_PERIOD (BASE_PERIOD),
        .STEP        (STEP),
        .SLEEP_EXTRA (SLEEP_EXTRA),
        .MIN_PERIOD  (MIN_PERIOD),
        .SLEW_STEP   (SLEW_STEP)
    ) u_slew (
        .i_level       (hb.heartbeat_level),
        .i_sleeping    (hb.sleeping),
        .i_period      (r_period),
        .o_next_period (w_slewed)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period;
        w_count_nxt  = r_count;
        w_beat_nxt   = 1'b0;
        if (!hb.en) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (hb.tick) begin
            if (r_state == ST_IDLE || r_cnt == r_period - c_ONE) begin
                w_state_nxt = ST_SYSTOLE;
                w_cnt_nxt   = '0;
                w_beat_nxt  = 1'b1;
                w_count_nxt = r_count + 8'd1;
                // Leaving IDLE restarts at the retained period without slewing.
                if (r_state != ST_IDLE)
                    w_period_nxt = w_slewed;
            end else begin
                w_cnt_nxt = r_cnt + c_ONE;
                if (r_state == ST_SYSTOLE && r_cnt == c_PULSE_LAST)
                    w_state_nxt = ST_DIASTOLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_period <= c_RESET_PERIOD;
            r_count  <= '0;
            r_beat   <= 1'b0;
            r_led    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_period <= w_period_nxt;
            r_count  <= w_count_nxt;
            r_beat   <= w_beat_nxt;
            r_led    <= (w_state_nxt == ST_SYSTOLE);
        end
    end

    assign hb.beat       = r_beat;
    assign hb.beat_led   = r_led;
    assign hb.period     = r_period;
    assign hb.beat_count = r_count;
endmodule
`default_nettype wire
